// File: rtl/interval_pkg.sv
// Shared types and helpers for the interval classifier: floating-point format
// descriptors, NaN detection and the total-order compare key.
package interval_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    localparam int unsigned MAX_W = 64;

    // Raw bit pattern of the widest supported format; narrower values are zero-extended.
    typedef logic [MAX_W-1:0] fp_raw_t;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 5;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 10;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    function automatic logic fp_is_nan(fp_format_e fmt, fp_raw_t v);
        int unsigned m;
        int unsigned e;
        logic exp_ones;
        logic man_nz;
        m = man_bits(fmt);
        e = exp_bits(fmt);
        exp_ones = 1'b1;
        man_nz   = 1'b0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < m) begin
                man_nz = man_nz | v[i];
            end else if (i < m + e) begin
                exp_ones = exp_ones & v[i];
            end
        end
        return exp_ones & man_nz;
    endfunction

    // Maps a non-NaN value to an unsigned key whose order matches the numeric
    // order; both zeros map to the same key so -0 compares equal to +0.
    function automatic fp_raw_t order_key(fp_format_e fmt, fp_raw_t v);
        int unsigned w;
        fp_raw_t top;
        fp_raw_t mask;
        w    = fp_width(fmt);
        top  = fp_raw_t'(1) << (w - 1);
        mask = top - fp_raw_t'(1);
        if ((v & mask) == '0) begin
            return top;
        end
        if ((v & top) != '0) begin
            return ~v & mask;
        end
        return (v & mask) | top;
    endfunction

endpackage

// File: rtl/interval_fp_ge.sv
// Combinational a >= b comparator on the floating-point total order, with a
// NaN flag for operand a.
module interval_fp_ge import interval_pkg::*; #(
    parameter fp_format_e FpFormat = FP16,
    localparam int unsigned WIDTH = fp_width(FpFormat)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ge_o,
    output logic             is_nan_o
);

    always_comb begin
        ge_o     = order_key(FpFormat, fp_raw_t'(a_i)) >= order_key(FpFormat, fp_raw_t'(b_i));
        is_nan_o = fp_is_nan(FpFormat, fp_raw_t'(a_i));
    end

endmodule

// File: rtl/interval_classifier.sv
// Two-stage pipelined classifier: compares each sample against programmable
// boundaries, emits one-hot/binary interval codes and keeps a hit histogram.
module interval_classifier import interval_pkg::*; #(
    parameter fp_format_e  FpFormat = FP16,
    parameter int unsigned NUM_INT  = 8,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned WIDTH   = fp_width(FpFormat),
    localparam int unsigned IDX_W   = $clog2(NUM_INT),
    localparam int unsigned NUM_BND = NUM_INT - 1,
    localparam int unsigned BND_AW  = (NUM_BND > 1) ? $clog2(NUM_BND) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WIDTH-1:0]         s_i,
    input  logic                     bnd_we_i,
    input  logic [BND_AW-1:0]        bnd_addr_i,
    input  logic [WIDTH-1:0]         bnd_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_INT-1:0]       interval_o,
    output logic [IDX_W-1:0]         index_o,
    output logic                     nan_o,
    input  logic                     hist_clr_i,
    output logic [NUM_INT*CNT_W-1:0] hist_o
);

    typedef logic [WIDTH-1:0] bnd_t;
    typedef logic [CNT_W-1:0] cnt_t;

    bnd_t bnd_q [NUM_BND];
    bnd_t bnd_d [NUM_BND];
    cnt_t hist_q [NUM_INT];
    cnt_t hist_d [NUM_INT];

    logic [NUM_BND-1:0] ge;
    logic [NUM_BND-1:0] ge_nan;
    logic               sample_nan;

    logic               s1_valid_q, s1_valid_d;
    logic [NUM_BND-1:0] s1_therm_q, s1_therm_d;
    logic               s1_nan_q, s1_nan_d;

    logic               out_valid_q, out_valid_d;
    logic [NUM_INT-1:0] interval_q, interval_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               nan_q, nan_d;

    logic               s2_adv, s1_adv, hit;
    logic [NUM_INT:0]   therm;
    logic [NUM_INT-1:0] interval_c;
    logic [IDX_W-1:0]   index_c;

    for (genvar g = 0; g < NUM_BND; g++) begin : g_cmp
        interval_fp_ge #(.FpFormat(FpFormat)) u_ge (
            .a_i      (s_i),
            .b_i      (bnd_q[g]),
            .ge_o     (ge[g]),
            .is_nan_o (ge_nan[g])
        );
    end

    always_comb begin
        sample_nan = |ge_nan;
        s2_adv     = !out_valid_q || out_ready_i;
        s1_adv     = !s1_valid_q || s2_adv;
        in_ready_o = s1_adv;
        hit        = out_valid_q && out_ready_i && !nan_q;
    end

    always_comb begin
        for (int i = 0; i < NUM_BND; i++) begin
            bnd_d[i] = bnd_q[i];
            if (bnd_we_i && (bnd_addr_i == BND_AW'(i))) begin
                bnd_d[i] = bnd_data_i;
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_therm_d = s1_therm_q;
        s1_nan_d   = s1_nan_q;
        if (s1_adv) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_therm_d = ge;
                s1_nan_d   = sample_nan;
            end
        end
    end

    // Index tracks the highest set thermometer bit, so multi-hot codes from
    // unsorted boundaries still yield a single well-defined index.
    always_comb begin
        therm      = {1'b0, s1_therm_q, 1'b1};
        interval_c = '0;
        index_c    = '0;
        for (int k = 0; k < NUM_INT; k++) begin
            interval_c[k] = therm[k] ^ therm[k+1];
            if (therm[k]) begin
                index_c = IDX_W'(k);
            end
        end
        if (s1_nan_q) begin
            interval_c = '0;
            index_c    = '0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        interval_d  = interval_q;
        index_d     = index_q;
        nan_d       = nan_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                interval_d = interval_c;
                index_d    = index_c;
                nan_d      = s1_nan_q;
            end
        end
    end

    always_comb begin
        hist_o = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            hist_d[i] = hist_q[i];
            if (hit && (index_q == IDX_W'(i)) && (hist_q[i] != '1)) begin
                hist_d[i] = hist_q[i] + cnt_t'(1);
            end
            if (hist_clr_i) begin
                hist_d[i] = '0;
            end
            hist_o[i*CNT_W +: CNT_W] = hist_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_therm_q  <= '0;
            s1_nan_q    <= 1'b0;
            out_valid_q <= 1'b0;
            interval_q  <= '0;
            index_q     <= '0;
            nan_q       <= 1'b0;
            for (int i = 0; i < NUM_BND; i++) begin
                bnd_q[i] <= '0;
            end
            for (int i = 0; i < NUM_INT; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_therm_q  <= s1_therm_d;
            s1_nan_q    <= s1_nan_d;
            out_valid_q <= out_valid_d;
            interval_q  <= interval_d;
            index_q     <= index_d;
            nan_q       <= nan_d;
            for (int i = 0; i < NUM_BND; i++) begin
                bnd_q[i] <= bnd_d[i];
            end
            for (int i = 0; i < NUM_INT; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    always_comb begin
        out_valid_o = out_valid_q;
        interval_o  = interval_q;
        index_o     = index_q;
        nan_o       = nan_q;
    end

endmodule
